// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: instruction width and FSM state encodings.
package program_loader_pkg;

    localparam int INSTR_W = 32;

    typedef logic [2:0] loaderStateT;

    localparam loaderStateT IDLE     = 3'd0;
    localparam loaderStateT PRE_RST  = 3'd1;
    localparam loaderStateT STREAM   = 3'd2;
    localparam loaderStateT POST_RST = 3'd3;
    localparam loaderStateT RUN      = 3'd4;

endpackage

// File: rtl/loader_buffer.sv
// Instruction word buffer: one write port and one read port with a registered read.
// When readEn is low the read register loads zero, so the output idles at zero.
module loader_buffer
    import program_loader_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               writeEn,
    input  logic [AW-1:0]      writeAddr,
    input  logic [INSTR_W-1:0] writeData,
    input  logic               readEn,
    input  logic [AW-1:0]      readAddr,
    output logic [INSTR_W-1:0] readData
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[writeAddr] <= writeData;
        end
        readData <= readEn ? mem[readAddr] : '0;
    end

endmodule

// File: rtl/program_loader.sv
// Buffers upstream instruction words and replays them into the CPU load port,
// framed by CPU reset pulses, before releasing the CPU into run mode.
module program_loader
    import program_loader_pkg::*;
#(
    parameter  int DEPTH      = 32,
    parameter  int RST_CYCLES = 2,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [INSTR_W-1:0] WordIn,
    input  logic               WordValid,
    output logic               WordReady,
    input  logic               Start,
    input  logic               Clear,
    output logic               CpuReset,
    output logic               LoadInstructions,
    output logic [INSTR_W-1:0] Instruction,
    output logic [CW-1:0]      WordCount,
    output logic               Busy,
    output logic               Done
);

    localparam int RW = $clog2(RST_CYCLES + 1);

    loaderStateT   state;
    loaderStateT   nextState;
    logic [CW-1:0] nextCount;
    logic [AW-1:0] streamIdx;
    logic [AW-1:0] readAddr;
    logic [RW-1:0] rstCnt;
    logic          transfer;
    logic          writeEn;
    logic          lastWord;
    logic          rstDone;
    logic          readEn;

    assign transfer = (state == IDLE) && WordValid && WordReady && !Clear;
    assign writeEn  = transfer && !Reset;
    assign lastWord = ({1'b0, streamIdx} == WordCount - CW'(1));
    assign rstDone  = (rstCnt == RW'(RST_CYCLES - 1));

    // Address runs one word ahead of the STREAM cycle so the registered read lines up with LoadInstructions.
    assign readAddr = (state == PRE_RST) ? '0 : streamIdx + AW'(1);
    assign readEn   = !Reset && ((state == PRE_RST) || ((state == STREAM) && !lastWord));

    loader_buffer #(
        .DEPTH(DEPTH)
    ) u_buffer (
        .clk      (clk),
        .writeEn  (writeEn),
        .writeAddr(WordCount[AW-1:0]),
        .writeData(WordIn),
        .readEn   (readEn),
        .readAddr (readAddr),
        .readData (Instruction)
    );

    always_comb begin
        nextState = state;
        nextCount = WordCount;
        case (state)
            IDLE: begin
                if (Clear) begin
                    nextCount = '0;
                end else begin
                    if (transfer) begin
                        nextCount = WordCount + CW'(1);
                    end
                    if (Start && (WordCount != '0)) begin
                        nextState = PRE_RST;
                    end
                end
            end
            PRE_RST:  nextState = STREAM;
            STREAM:   if (lastWord) nextState = POST_RST;
            POST_RST: if (rstDone) nextState = RUN;
            RUN: begin
                if (Clear) begin
                    nextState = IDLE;
                    nextCount = '0;
                end else if (Start) begin
                    nextState = PRE_RST;
                end
            end
            default:  nextState = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state            <= IDLE;
            WordCount        <= '0;
            streamIdx        <= '0;
            rstCnt           <= '0;
            WordReady        <= 1'b0;
            CpuReset         <= 1'b1;
            LoadInstructions <= 1'b0;
            Busy             <= 1'b0;
            Done             <= 1'b0;
        end else begin
            state            <= nextState;
            WordCount        <= nextCount;
            streamIdx        <= ((state == STREAM) && !lastWord) ? streamIdx + AW'(1) : '0;
            rstCnt           <= (state == POST_RST) ? rstCnt + RW'(1) : '0;
            WordReady        <= (nextState == IDLE) && (nextCount < CW'(DEPTH));
            CpuReset         <= (nextState == IDLE) || (nextState == PRE_RST) || (nextState == POST_RST);
            LoadInstructions <= (nextState == STREAM);
            Busy             <= (nextState == PRE_RST) || (nextState == STREAM) || (nextState == POST_RST);
            Done             <= (nextState == RUN);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: loading, streaming, re-streaming,
// clear/start priority, the full-buffer boundary and reset mid-stream.
module tb_program_loader;

    localparam int DEPTH      = 32;
    localparam int RST_CYCLES = 2;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] WordIn;
    logic        WordValid;
    logic        WordReady;
    logic        Start;
    logic        Clear;
    logic        CpuReset;
    logic        LoadInstructions;
    logic [31:0] Instruction;
    logic [5:0]  WordCount;
    logic        Busy;
    logic        Done;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] expWords[$];

    program_loader #(
        .DEPTH(DEPTH),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk             (clk),
        .Reset           (Reset),
        .WordIn          (WordIn),
        .WordValid       (WordValid),
        .WordReady       (WordReady),
        .Start           (Start),
        .Clear           (Clear),
        .CpuReset        (CpuReset),
        .LoadInstructions(LoadInstructions),
        .Instruction     (Instruction),
        .WordCount       (WordCount),
        .Busy            (Busy),
        .Done            (Done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] word, input logic start, input logic clear);
        WordValid = valid;
        WordIn    = word;
        Start     = start;
        Clear     = clear;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        Reset = 1'b0;
    endtask

    task automatic loadWord(input logic [31:0] w);
        int guard = 0;
        applyStimulus(1'b1, w, 1'b0, 1'b0);
        while (!WordReady && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("loadReady", {31'b0, WordReady}, 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic pulseStart();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic clearToIdle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("clearDone", {31'b0, Done}, 32'd0);
        checkOutput("clearCount", {26'b0, WordCount}, 32'd0);
    endtask

    // Entered in the PRE_RST cycle; walks the whole stream and post-reset window into RUN.
    task automatic checkStream(input string tag);
        checkOutput({tag, ".preCpuReset"}, {31'b0, CpuReset}, 32'd1);
        checkOutput({tag, ".preLoad"}, {31'b0, LoadInstructions}, 32'd0);
        checkOutput({tag, ".preBusy"}, {31'b0, Busy}, 32'd1);
        tick();
        foreach (expWords[k]) begin
            checkOutput({tag, ".load"}, {31'b0, LoadInstructions}, 32'd1);
            checkOutput({tag, ".cpuReset"}, {31'b0, CpuReset}, 32'd0);
            checkOutput({tag, ".instr"}, Instruction, expWords[k]);
            tick();
        end
        for (int r = 0; r < RST_CYCLES; r++) begin
            checkOutput({tag, ".postCpuReset"}, {31'b0, CpuReset}, 32'd1);
            checkOutput({tag, ".postLoad"}, {31'b0, LoadInstructions}, 32'd0);
            checkOutput({tag, ".postInstr"}, Instruction, 32'h0);
            checkOutput({tag, ".postDone"}, {31'b0, Done}, 32'd0);
            tick();
        end
        checkOutput({tag, ".runDone"}, {31'b0, Done}, 32'd1);
        checkOutput({tag, ".runCpuReset"}, {31'b0, CpuReset}, 32'd0);
        checkOutput({tag, ".runBusy"}, {31'b0, Busy}, 32'd0);
        checkOutput({tag, ".runLoad"}, {31'b0, LoadInstructions}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state
        doReset();
        checkOutput("rstCpuReset", {31'b0, CpuReset}, 32'd1);
        checkOutput("rstLoad", {31'b0, LoadInstructions}, 32'd0);
        checkOutput("rstInstr", Instruction, 32'h0);
        checkOutput("rstCount", {26'b0, WordCount}, 32'd0);
        checkOutput("rstBusy", {31'b0, Busy}, 32'd0);
        checkOutput("rstDone", {31'b0, Done}, 32'd0);
        checkOutput("rstReady", {31'b0, WordReady}, 32'd0);
        tick();
        checkOutput("idleReady", {31'b0, WordReady}, 32'd1);

        // Three-word program
        expWords = '{32'h20010005, 32'h20020003, 32'h00221820};
        foreach (expWords[i]) loadWord(expWords[i]);
        checkOutput("threeCount", {26'b0, WordCount}, 32'd3);
        pulseStart();
        checkStream("three");

        // Start with an empty buffer is ignored
        clearToIdle();
        pulseStart();
        for (int c = 0; c < 3; c++) begin
            checkOutput("emptyCpuReset", {31'b0, CpuReset}, 32'd1);
            checkOutput("emptyLoad", {31'b0, LoadInstructions}, 32'd0);
            checkOutput("emptyBusy", {31'b0, Busy}, 32'd0);
            tick();
        end

        // Start together with a transferred word includes that word last
        loadWord(32'h11111111);
        checkOutput("sameCycleReady", {31'b0, WordReady}, 32'd1);
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        expWords = '{32'h11111111, 32'hDEADBEEF};
        checkOutput("sameCycleCount", {26'b0, WordCount}, 32'd2);
        checkStream("sameCycle");
        clearToIdle();

        // Four words, stream, re-stream from RUN, then Clear beats Start
        expWords = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4};
        foreach (expWords[i]) loadWord(expWords[i]);
        pulseStart();
        checkStream("four");
        pulseStart();
        checkStream("restream");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("clrStartCount", {26'b0, WordCount}, 32'd0);
        checkOutput("clrStartBusy", {31'b0, Busy}, 32'd0);
        checkOutput("clrStartCpuReset", {31'b0, CpuReset}, 32'd1);
        checkOutput("clrStartDone", {31'b0, Done}, 32'd0);
        tick();
        checkOutput("clrStartLoad", {31'b0, LoadInstructions}, 32'd0);
        checkOutput("clrStartReady", {31'b0, WordReady}, 32'd1);

        // Reset during the second STREAM cycle aborts at once
        expWords = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        foreach (expWords[i]) loadWord(expWords[i]);
        pulseStart();
        tick();
        tick();
        checkOutput("abortSecondWord", Instruction, 32'h05060708);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("abortLoad", {31'b0, LoadInstructions}, 32'd0);
        checkOutput("abortCpuReset", {31'b0, CpuReset}, 32'd1);
        checkOutput("abortCount", {26'b0, WordCount}, 32'd0);
        checkOutput("abortDone", {31'b0, Done}, 32'd0);
        checkOutput("abortBusy", {31'b0, Busy}, 32'd0);
        checkOutput("abortInstr", Instruction, 32'h0);
        tick();

        // Full buffer: 33rd word is held off, exactly 32 words stream
        expWords.delete();
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("fillReady", {31'b0, WordReady}, 32'd1);
            applyStimulus(1'b1, 32'hC0DE0000 + i, 1'b0, 1'b0);
            expWords.push_back(32'hC0DE0000 + i);
            tick();
        end
        applyStimulus(1'b1, 32'hC0DE0020, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("fullReady", {31'b0, WordReady}, 32'd0);
            checkOutput("fullCount", {26'b0, WordCount}, 32'd32);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        pulseStart();
        checkStream("full");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
